operand_fetch_stage: RTL and testbench

- Decode→execute pipeline stage that sits directly downstream of the register file's read ports.
- Drives the two read addresses and captures the read data.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and inserts load-use bubbles.
- Registers operands into a single-entry output buffer toward EX, with a valid/ready handshake.

---
 rtl/core_pkg.sv | 18 +
 rtl/operand_fwd_mux.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants and forwarding-select encoding.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 16;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand selector: zero register, EX, MEM, same-cycle WB, then register file.
module operand_fwd_mux
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] idx,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [XLEN-1:0]   rf_data,
    output logic [XLEN-1:0]   val_c
);

    fwd_sel_e sel;

    // Pick the youngest producer; a load in EX has no data yet so it never forwards.
    always_comb begin
        sel = FWD_RF;
        if (idx == REG_ZERO) begin
            sel = FWD_ZERO;
        end else if (ex_wen && (ex_rd == idx) && !ex_is_load) begin
            sel = FWD_EX;
        end else if (mem_wen && (mem_rd == idx)) begin
            sel = FWD_MEM;
        end else if (wb_wen && (wb_addr == idx)) begin
            sel = FWD_WB;
        end
    end

    // Data mux driven by the select.
    always_comb begin
        val_c = rf_data;
        case (sel)
            FWD_ZERO: val_c = '0;
            FWD_EX:   val_c = ex_data;
            FWD_MEM:  val_c = mem_data;
            FWD_WB:   val_c = wb_data;
            default:  val_c = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: RF read, forwarding, load-use bubbles, one-entry output buffer.
// Optional performance counters enabled by defining OF_PERF_CNT_EN.
module operand_fetch_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [REG_AW-1:0] rf_addr_r1,
    output logic [REG_AW-1:0] rf_addr_r2,
    input  logic [XLEN-1:0]   rf_data_r1,
    input  logic [XLEN-1:0]   rf_data_r2,
    input  logic              ex_fwd_wen,
    input  logic              ex_fwd_is_load,
    input  logic [REG_AW-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              mem_fwd_wen,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef OF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic [XLEN-1:0] rs1_val_c;
    logic [XLEN-1:0] rs2_val_c;
    logic            hz;
    logic            slot_free;
    logic            xfer;
    logic            out_valid_next;

    assign rf_addr_r1 = in_rs1;
    assign rf_addr_r2 = in_rs2;

    operand_fwd_mux u_fwd_rs1 (
        .idx        (in_rs1),
        .ex_wen     (ex_fwd_wen),
        .ex_is_load (ex_fwd_is_load),
        .ex_rd      (ex_fwd_rd),
        .ex_data    (ex_fwd_data),
        .mem_wen    (mem_fwd_wen),
        .mem_rd     (mem_fwd_rd),
        .mem_data   (mem_fwd_data),
        .wb_wen     (wb_wen),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_data    (rf_data_r1),
        .val_c      (rs1_val_c)
    );

    operand_fwd_mux u_fwd_rs2 (
        .idx        (in_rs2),
        .ex_wen     (ex_fwd_wen),
        .ex_is_load (ex_fwd_is_load),
        .ex_rd      (ex_fwd_rd),
        .ex_data    (ex_fwd_data),
        .mem_wen    (mem_fwd_wen),
        .mem_rd     (mem_fwd_rd),
        .mem_data   (mem_fwd_data),
        .wb_wen     (wb_wen),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_data    (rf_data_r2),
        .val_c      (rs2_val_c)
    );

    // Load-use hazard, handshake and next valid; flush overrides everything.
    always_comb begin
        hz = in_valid && ex_fwd_wen && ex_fwd_is_load && (ex_fwd_rd != REG_ZERO) &&
             ((in_use_rs1 && (in_rs1 == ex_fwd_rd)) || (in_use_rs2 && (in_rs2 == ex_fwd_rd)));
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && !hz && !flush;
        xfer      = in_valid && in_ready;
        out_valid_next = out_valid;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (xfer) begin
            out_valid_next = 1'b1;
        end else if (slot_free) begin
            out_valid_next = 1'b0;
        end
    end

    // Output buffer; payload only moves on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_ctrl    <= '0;
        end else begin
            out_valid <= out_valid_next;
            if (xfer) begin
                out_pc      <= in_pc;
                out_rs1_val <= rs1_val_c;
                out_rs2_val <= rs2_val_c;
                out_rd      <= in_rd;
                out_ctrl    <= in_ctrl;
            end
        end
    end

`ifdef OF_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] perf_stall_q;
    logic [31:0] perf_bubble_q;

    assign perf_stall_cnt  = perf_stall_q;
    assign perf_bubble_cnt = perf_bubble_q;

    // Saturating stall and bubble counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (hz && (perf_stall_q != CNT_MAX)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (slot_free && !out_valid_next && (perf_bubble_q != CNT_MAX)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus randomized model check.
module tb_operand_fetch_stage;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic              in_use_rs1, in_use_rs2;
    logic [CTRL_W-1:0] in_ctrl;
    logic [REG_AW-1:0] rf_addr_r1, rf_addr_r2;
    logic [XLEN-1:0]   rf_data_r1, rf_data_r2;
    logic              ex_fwd_wen, ex_fwd_is_load;
    logic [REG_AW-1:0] ex_fwd_rd;
    logic [XLEN-1:0]   ex_fwd_data;
    logic              mem_fwd_wen;
    logic [REG_AW-1:0] mem_fwd_rd;
    logic [XLEN-1:0]   mem_fwd_data;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc, out_rs1_val, out_rs2_val;
    logic [REG_AW-1:0] out_rd;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef OF_PERF_CNT_EN
    logic [31:0]       perf_stall_cnt, perf_bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_use_rs1     (in_use_rs1),
        .in_use_rs2     (in_use_rs2),
        .in_rd          (in_rd),
        .in_ctrl        (in_ctrl),
        .rf_addr_r1     (rf_addr_r1),
        .rf_addr_r2     (rf_addr_r2),
        .rf_data_r1     (rf_data_r1),
        .rf_data_r2     (rf_data_r2),
        .ex_fwd_wen     (ex_fwd_wen),
        .ex_fwd_is_load (ex_fwd_is_load),
        .ex_fwd_rd      (ex_fwd_rd),
        .ex_fwd_data    (ex_fwd_data),
        .mem_fwd_wen    (mem_fwd_wen),
        .mem_fwd_rd     (mem_fwd_rd),
        .mem_fwd_data   (mem_fwd_data),
        .wb_wen         (wb_wen),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rs1_val    (out_rs1_val),
        .out_rs2_val    (out_rs2_val),
        .out_rd         (out_rd),
        .out_ctrl       (out_ctrl)
`ifdef OF_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd = '0; in_ctrl = '0;
        rf_data_r1 = '0; rf_data_r2 = '0;
        ex_fwd_wen = 1'b0; ex_fwd_is_load = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        mem_fwd_wen = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_wen = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    endtask

    // Reference operand value from the priority rules.
    function automatic logic [XLEN-1:0] ref_operand(input logic [REG_AW-1:0] idx,
                                                    input logic [XLEN-1:0] rf);
        if (idx == 0) return '0;
        if (ex_fwd_wen && !ex_fwd_is_load && ex_fwd_rd == idx) return ex_fwd_data;
        if (mem_fwd_wen && mem_fwd_rd == idx) return mem_fwd_data;
        if (wb_wen && wb_addr == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic waits_on_load;
        waits_on_load = ex_fwd_wen && ex_fwd_is_load && ex_fwd_rd != 0;
        return in_valid && waits_on_load &&
               ((in_use_rs1 && in_rs1 == ex_fwd_rd) || (in_use_rs2 && in_rs2 == ex_fwd_rd));
    endfunction

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        in_valid = 1'b1; in_pc = 32'h1234_5678; in_rs1 = 5'd3; in_rd = 5'd9; in_ctrl = 16'hBEEF;
        rf_data_r1 = 32'h5555_5555;
        tick();
        tick();
        checks++;
        if ({out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_ctrl} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%0b pc=%h rs1=%h rs2=%h rd=%0d ctrl=%h required all zero",
                     out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_ctrl);
        end
        drive_idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_idle();
        in_valid = 1'b1; in_pc = 32'h0000_0100; in_rs1 = 5'd3; in_rs2 = 5'd4;
        in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; in_rd = 5'd6; in_ctrl = 16'h00A5;
        rf_data_r1 = 32'h11; rf_data_r2 = 32'h22;
        #1;
        checks++;
        if (rf_addr_r1 !== 5'd3 || rf_addr_r2 !== 5'd4) begin
            errors++;
            $display("FAIL rf_addr: got %0d/%0d required 3/4", rf_addr_r1, rf_addr_r2);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h11 || out_rs2_val !== 32'h22 ||
            out_pc !== 32'h100 || out_rd !== 5'd6 || out_ctrl !== 16'h00A5) begin
            errors++;
            $display("FAIL basic: valid=%0b rs1=%h rs2=%h pc=%h rd=%0d ctrl=%h required 1/11/22/100/6/00a5",
                     out_valid, out_rs1_val, out_rs2_val, out_pc, out_rd, out_ctrl);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_fwd_priority();
        logic [XLEN-1:0] exp_val [4];
        exp_val[0] = 32'hAAAA; exp_val[1] = 32'hBBBB; exp_val[2] = 32'hCCCC; exp_val[3] = 32'h0;
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            in_valid = 1'b1; in_use_rs1 = 1'b1; in_rs1 = (c == 3) ? 5'd0 : 5'd5;
            rf_data_r1 = 32'hDEAD;
            ex_fwd_wen  = (c == 0 || c == 3); ex_fwd_rd  = in_rs1; ex_fwd_data  = 32'hAAAA;
            mem_fwd_wen = (c <= 1 || c == 3); mem_fwd_rd = in_rs1; mem_fwd_data = 32'hBBBB;
            wb_wen      = 1'b1;               wb_addr    = in_rs1; wb_data      = 32'hCCCC;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_rs1_val !== exp_val[c]) begin
                errors++;
                $display("FAIL fwd_prio case %0d: valid=%0b rs1=%h required 1/%h",
                         c, out_valid, out_rs1_val, exp_val[c]);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_load_use();
        drive_idle();
        ex_fwd_wen = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hFFFF;
        in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd7; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
        rf_data_r1 = 32'h1; rf_data_r2 = 32'h9999; in_pc = 32'h200;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: in_ready=%0b required 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: out_valid=%0b required 0", out_valid);
        end
        ex_fwd_wen = 1'b0; ex_fwd_is_load = 1'b0;
        mem_fwd_wen = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: in_ready=%0b required 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rs2_val !== 32'h1234 || out_pc !== 32'h200) begin
            errors++;
            $display("FAIL load_use_fwd: valid=%0b rs2=%h pc=%h required 1/1234/200",
                     out_valid, out_rs2_val, out_pc);
        end
        mem_fwd_wen = 1'b0;
        ex_fwd_wen = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
        in_use_rs2 = 1'b0; in_pc = 32'h204;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_use_unused: in_ready=%0b required 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_rs2_val !== 32'h9999) begin
            errors++;
            $display("FAIL load_use_unused_xfer: valid=%0b pc=%h rs2=%h required 1/204/9999",
                     out_valid, out_pc, out_rs2_val);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_backpressure();
        drive_idle();
        in_valid = 1'b1; in_pc = 32'h300; in_rs1 = 5'd2; in_use_rs1 = 1'b1;
        rf_data_r1 = 32'hA0A0; in_rd = 5'd3; in_ctrl = 16'h0303;
        tick();
        out_ready = 1'b0;
        in_pc = 32'h304; rf_data_r1 = 32'hB0B0; in_rd = 5'd4; in_ctrl = 16'h0404;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready cycle %0d: in_ready=%0b required 0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_rs1_val !== 32'hA0A0 ||
                out_rd !== 5'd3 || out_ctrl !== 16'h0303) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%0b pc=%h rs1=%h rd=%0d ctrl=%h required 1/300/a0a0/3/0303",
                         i, out_valid, out_pc, out_rs1_val, out_rd, out_ctrl);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%0b required 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_rs1_val !== 32'hB0B0) begin
            errors++;
            $display("FAIL bp_next: valid=%0b pc=%h rs1=%h required 1/304/b0b0",
                     out_valid, out_pc, out_rs1_val);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; flush = 1'b1;
        in_valid = 1'b1; in_pc = 32'h400; in_rs1 = 5'd2; rf_data_r1 = 32'hC0C0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%0b required 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h304) begin
            errors++;
            $display("FAIL flush_kill: valid=%0b pc=%h required 0/304", out_valid, out_pc);
        end
        flush = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_rs1_val !== 32'hC0C0) begin
            errors++;
            $display("FAIL flush_after: valid=%0b pc=%h rs1=%h required 1/400/c0c0",
                     out_valid, out_pc, out_rs1_val);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        logic              m_valid;
        logic [XLEN-1:0]   m_pc, m_rs1, m_rs2;
        logic [REG_AW-1:0] m_rd;
        logic [CTRL_W-1:0] m_ctrl;
        logic              e_ready, e_slot;
        // Start from a known empty buffer.
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
        for (int n = 0; n < 400; n++) begin
            rst_n          = ($urandom_range(0, 99) >= 3);
            flush          = ($urandom_range(0, 99) < 8);
            in_valid       = ($urandom_range(0, 99) < 75);
            out_ready      = ($urandom_range(0, 99) < 70);
            in_pc          = $urandom;
            in_rs1         = 5'($urandom_range(0, 7));
            in_rs2         = 5'($urandom_range(0, 7));
            in_use_rs1     = 1'($urandom_range(0, 1));
            in_use_rs2     = 1'($urandom_range(0, 1));
            in_rd          = 5'($urandom_range(0, 31));
            in_ctrl        = 16'($urandom);
            rf_data_r1     = $urandom;
            rf_data_r2     = $urandom;
            ex_fwd_wen     = 1'($urandom_range(0, 1));
            ex_fwd_is_load = ($urandom_range(0, 99) < 35);
            ex_fwd_rd      = 5'($urandom_range(0, 7));
            ex_fwd_data    = $urandom;
            mem_fwd_wen    = 1'($urandom_range(0, 1));
            mem_fwd_rd     = 5'($urandom_range(0, 7));
            mem_fwd_data   = $urandom;
            wb_wen         = 1'($urandom_range(0, 1));
            wb_addr        = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            #1;
            e_slot  = !m_valid || out_ready;
            e_ready = e_slot && !ref_hazard() && !flush;
            checks++;
            if (in_ready !== e_ready) begin
                errors++;
                $display("FAIL rand_in_ready step %0d: got %0b required %0b", n, in_ready, e_ready);
            end
            if (!rst_n) begin
                m_valid = 1'b0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
            end else if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && e_ready) begin
                m_valid = 1'b1;
                m_pc    = in_pc;
                m_rs1   = ref_operand(in_rs1, rf_data_r1);
                m_rs2   = ref_operand(in_rs2, rf_data_r2);
                m_rd    = in_rd;
                m_ctrl  = in_ctrl;
            end else if (e_slot) begin
                m_valid = 1'b0;
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_pc !== m_pc || out_rs1_val !== m_rs1 ||
                out_rs2_val !== m_rs2 || out_rd !== m_rd || out_ctrl !== m_ctrl) begin
                errors++;
                $display("FAIL rand_out step %0d: got v=%0b pc=%h a=%h b=%h rd=%0d c=%h required v=%0b pc=%h a=%h b=%h rd=%0d c=%h",
                         n, out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
                         m_valid, m_pc, m_rs1, m_rs2, m_rd, m_ctrl);
            end
        end
        rst_n = 1'b1;
        drive_idle();
        tick();
    endtask

`ifdef OF_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [31:0] b0;
        drive_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        b0 = perf_bubble_cnt;
        ex_fwd_wen = 1'b1; ex_fwd_is_load = 1'b1; ex_fwd_rd = 5'd7;
        in_valid = 1'b1; in_rs1 = 5'd7; in_use_rs1 = 1'b1;
        tick();
        tick();
        checks++;
        if (perf_stall_cnt !== 32'd2 || perf_bubble_cnt !== b0 + 32'd2) begin
            errors++;
            $display("FAIL perf_count: stall=%0d bubble=%0d required 2/%0d",
                     perf_stall_cnt, perf_bubble_cnt, b0 + 32'd2);
        end
        force dut.perf_stall_q  = 32'hFFFF_FFFF;
        force dut.perf_bubble_q = 32'hFFFF_FFFF;
        tick();
        release dut.perf_stall_q;
        release dut.perf_bubble_q;
        tick();
        tick();
        checks++;
        if (perf_stall_cnt !== 32'hFFFF_FFFF || perf_bubble_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL perf_saturate: stall=%h bubble=%h required ffffffff/ffffffff",
                     perf_stall_cnt, perf_bubble_cnt);
        end
        drive_idle();
        tick();
    endtask
`endif

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_fwd_priority();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
`ifdef OF_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
